// File: rtl/eeprom_pkg.sv
// Shared definitions for the EEPROM access arbiter and the I2C byte engine.
// Holds the arbiter state encoding, read/write encoding, default timing
// parameters, the I2C device-select bytes and a width helper.
package eeprom_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StIssue = 3'd1,
    StWait  = 3'd2,
    StHold  = 3'd3,
    StResp  = 3'd4
  } state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // 5 ms internal write cycle at 50 MHz.
  localparam int unsigned DEF_TWR_CYCLES = 250000;
  localparam int unsigned DEF_MAX_RETRY  = 3;

  // Device-select bytes used by the bit engine.
  localparam logic [7:0] DEV_SEL_WR = 8'hA0;
  localparam logic [7:0] DEV_SEL_RD = 8'hA1;

  // ceil(log2(n)), never below 1 so that it can size a vector.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/eeprom_access_arbiter_rr_grant.sv
// Combinational round-robin picker.
// Ports:
//   valid  in  NREQ    per-requester request
//   last   in  IDX_W   index granted most recently
//   grant  out NREQ    one-hot pick (first valid at or after last+1, wrapping)
//   idx    out IDX_W   index of the pick
//   found  out 1       any requester valid
module rr_grant
  import eeprom_pkg::*;
#(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned IDX_W = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0]  valid,
  input  logic [IDX_W-1:0] last,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    // Walk last+1 .. last+NREQ so the previous winner has lowest priority.
    for (int unsigned off = 1; off <= NREQ; off++) begin
      cand = IDX_W'((32'(last) + off) % NREQ);
      if (!found && valid[cand]) begin
        grant[cand] = 1'b1;
        idx         = cand;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/eeprom_access_arbiter.sv
// Round-robin arbiter sharing one byte-level I2C EEPROM engine between
// several requesters. One single-byte transaction is outstanding at a time;
// NACKed transactions are re-issued after a holdoff, and every successful
// write is followed by the EEPROM internal write-cycle holdoff.
// Ports:
//   clk, rst                       clock, synchronous active-low reset
//   req_valid/req_ready            per-requester handshake (ready is a 1-cycle pulse)
//   req_rw/req_addr/req_wdata      packed per-requester command fields
//   rsp_valid/rsp_rdata/rsp_err    one-hot completion pulse with read data / error
//   eng_start/eng_rw/eng_addr/eng_wdata  command to the bit engine
//   eng_busy/eng_done/eng_nack/eng_rdata status from the bit engine
// All outputs are registered.
module eeprom_access_arbiter
  import eeprom_pkg::*;
#(
  parameter int unsigned NREQ       = 2,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned TWR_CYCLES = DEF_TWR_CYCLES,
  parameter int unsigned MAX_RETRY  = DEF_MAX_RETRY
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ-1:0]        req_rw,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*8-1:0]      req_wdata,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [7:0]             rsp_rdata,
  output logic                   rsp_err,
  output logic                   eng_start,
  output logic                   eng_rw,
  output logic [ADDR_W-1:0]      eng_addr,
  output logic [7:0]             eng_wdata,
  input  logic                   eng_busy,
  input  logic                   eng_done,
  input  logic                   eng_nack,
  input  logic [7:0]             eng_rdata
);

  localparam int unsigned IDX_W = clog2_min1(NREQ);
  localparam int unsigned CNT_W = clog2_min1(TWR_CYCLES);
  localparam int unsigned RTY_W = clog2_min1(MAX_RETRY + 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic               rw_q, rw_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [7:0]         wdata_q, wdata_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic               retry_flag_q, retry_flag_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         rdata_q, rdata_d;
  logic [NREQ-1:0]    req_ready_q, req_ready_d;
  logic [NREQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [7:0]         rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;
  logic               eng_start_q, eng_start_d;

  logic [NREQ-1:0]    pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;

  rr_grant #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_grant (
    .valid (req_valid),
    .last  (last_q),
    .grant (pick_onehot),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    grant_d      = grant_q;
    rw_d         = rw_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    retry_d      = retry_q;
    retry_flag_d = retry_flag_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    req_ready_d  = '0;
    rsp_valid_d  = '0;
    rsp_rdata_d  = '0;
    rsp_err_d    = 1'b0;
    eng_start_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          req_ready_d  = pick_onehot;
          grant_d      = pick_idx;
          last_d       = pick_idx;
          rw_d         = req_rw[pick_idx];
          addr_d       = req_addr[pick_idx*ADDR_W +: ADDR_W];
          wdata_d      = req_wdata[pick_idx*8 +: 8];
          retry_d      = '0;
          retry_flag_d = 1'b0;
          err_d        = 1'b0;
          rdata_d      = '0;
          state_d      = StIssue;
        end
      end
      StIssue: begin
        if (!eng_busy) begin
          eng_start_d = 1'b1;
          state_d     = StWait;
        end
      end
      StWait: begin
        if (eng_done) begin
          // Flag must drop on success so a post-write holdoff ends in RESP.
          retry_flag_d = 1'b0;
          if (!eng_nack) begin
            if (rw_q == RW_READ) begin
              rdata_d = eng_rdata;
              state_d = StResp;
            end else begin
              cnt_d   = CNT_W'(TWR_CYCLES - 1);
              state_d = StHold;
            end
          end else if (retry_q < RTY_W'(MAX_RETRY)) begin
            retry_d      = retry_q + RTY_W'(1);
            retry_flag_d = 1'b1;
            cnt_d        = CNT_W'(TWR_CYCLES - 1);
            state_d      = StHold;
          end else begin
            err_d   = 1'b1;
            state_d = StResp;
          end
        end
      end
      StHold: begin
        cnt_d = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
        // Leave as the count steps from 1 to 0: the registered rsp_valid
        // then lands TWR_CYCLES+1 cycles after eng_done.
        if (cnt_q <= CNT_W'(1)) begin
          state_d = retry_flag_q ? StIssue : StResp;
        end
      end
      StResp: begin
        rsp_valid_d  = NREQ'(1) << grant_q;
        rsp_rdata_d  = rdata_q;
        rsp_err_d    = err_q;
        retry_flag_d = 1'b0;
        err_d        = 1'b0;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      last_q       <= IDX_W'(NREQ - 1);
      grant_q      <= '0;
      rw_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      retry_q      <= '0;
      retry_flag_q <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      rdata_q      <= '0;
      req_ready_q  <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      eng_start_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      grant_q      <= grant_d;
      rw_q         <= rw_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      retry_q      <= retry_d;
      retry_flag_q <= retry_flag_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      eng_start_q  <= eng_start_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign eng_start = eng_start_q;
  assign eng_rw    = rw_q;
  assign eng_addr  = addr_q;
  assign eng_wdata = wdata_q;

endmodule

// File: tb/tb_eeprom_access_arbiter.sv
// Self-checking bench for eeprom_access_arbiter with a cycle-level engine model.
module tb_eeprom_access_arbiter;

  localparam int unsigned NREQ    = 2;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned TWR     = 16;
  localparam int unsigned MAXR    = 2;
  localparam int          ENG_LAT = 40;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req_valid, req_ready, req_rw, rsp_valid;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*8-1:0]      req_wdata;
  logic [7:0]             rsp_rdata, eng_wdata, eng_rdata;
  logic                   rsp_err, eng_start, eng_rw, eng_busy, eng_done, eng_nack;
  logic [ADDR_W-1:0]      eng_addr;

  int errors = 0;
  int checks = 0;

  // Engine model and logs.
  int             cyc = 0;
  int             done_at = -1, busy_until = -1;
  bit             nack_q[$];
  logic [7:0]     rd_key = 8'h00;
  logic [7:0]     cur_addr;
  int             start_log[$], done_log[$];
  logic [7:0]     start_addr[$], start_wdata[$];
  logic           start_rw[$];
  int             rsp_cyc[$], rsp_who[$], grant_log[$], grant_cyc[$];
  logic [7:0]     rsp_dat[$];
  logic           rsp_e[$];
  int             busy_viol = 0, hold_viol = 0, onehot_viol = 0;
  int             rr_last = NREQ - 1;

  eeprom_access_arbiter #(
    .NREQ       (NREQ),
    .ADDR_W     (ADDR_W),
    .TWR_CYCLES (TWR),
    .MAX_RETRY  (MAXR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rw    (req_rw),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .eng_start (eng_start),
    .eng_rw    (eng_rw),
    .eng_addr  (eng_addr),
    .eng_wdata (eng_wdata),
    .eng_busy  (eng_busy),
    .eng_done  (eng_done),
    .eng_nack  (eng_nack),
    .eng_rdata (eng_rdata)
  );

  always #5 clk = ~clk;

  // Engine: done ENG_LAT cycles after start, busy a random tail beyond done.
  // Read data is rd_key ^ addr; nack bits come from nack_q, one per attempt.
  initial begin
    eng_busy = 1'b0; eng_done = 1'b0; eng_nack = 1'b0; eng_rdata = 8'h00;
    cur_addr = 8'h00;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (!rst) begin
        done_at = -1; busy_until = -1;
        eng_busy = 1'b0; eng_done = 1'b0; eng_nack = 1'b0; eng_rdata = 8'h00;
      end else begin
        eng_busy  = (cyc <= busy_until);
        eng_done  = (cyc == done_at);
        eng_rdata = 8'($urandom);
        eng_nack  = 1'($urandom);
        if (eng_done) begin
          done_log.push_back(cyc);
          eng_nack  = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
          eng_rdata = rd_key ^ cur_addr;
        end
        if (eng_start) begin
          start_log.push_back(cyc);
          start_addr.push_back(eng_addr);
          start_wdata.push_back(eng_wdata);
          start_rw.push_back(eng_rw);
          cur_addr   = eng_addr;
          done_at    = cyc + ENG_LAT;
          busy_until = done_at + int'($urandom_range(0, 6));
        end
      end
    end
  end

  // Requester side: drop req_valid on accept; log grants and responses.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int i = 0; i < NREQ; i++) begin
          if (req_ready[i]) begin
            req_valid[i] = 1'b0;
            grant_log.push_back(i);
            grant_cyc.push_back(cyc);
          end
        end
        if (rsp_valid != '0) begin
          if ($countones(rsp_valid) != 1) onehot_viol++;
          for (int i = 0; i < NREQ; i++) if (rsp_valid[i]) rsp_who.push_back(i);
          rsp_cyc.push_back(cyc);
          rsp_dat.push_back(rsp_rdata);
          rsp_e.push_back(rsp_err);
        end
        if (eng_start && eng_busy) busy_viol++;
        if (start_log.size() > 0 && cyc > start_log[$] && cyc <= done_at &&
            (eng_addr !== start_addr[$] || eng_wdata !== start_wdata[$] ||
             eng_rw !== start_rw[$])) hold_viol++;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int rr_pick(input logic [NREQ-1:0] pend, input int last);
    for (int off = 1; off <= NREQ; off++) begin
      if (pend[(last + off) % NREQ]) return (last + off) % NREQ;
    end
    return -1;
  endfunction

  task automatic clear_logs();
    start_log.delete(); done_log.delete(); start_addr.delete(); start_wdata.delete();
    start_rw.delete(); rsp_cyc.delete(); rsp_who.delete(); rsp_dat.delete();
    rsp_e.delete(); grant_log.delete(); grant_cyc.delete(); nack_q.delete();
    busy_viol = 0; hold_viol = 0; onehot_viol = 0;
  endtask

  task automatic drive_req(input int i, input logic rw, input logic [7:0] a,
                           input logic [7:0] wd);
    req_rw[i] = rw;
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_wdata[i*8 +: 8] = wd;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_rsp(input int want, input int bound);
    for (int n = 0; n < bound && rsp_cyc.size() < want; n++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_err} !== '0) begin
      errors++;
      $display("FAIL reset_rsp: got %h want 0", {req_ready, rsp_valid, rsp_rdata, rsp_err});
    end
    checks++;
    if ({eng_start, eng_rw, eng_addr, eng_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_eng: got %h want 0", {eng_start, eng_rw, eng_addr, eng_wdata});
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, eng_start} !== '0) begin
      errors++;
      $display("FAIL idle_quiet: got %h want 0", {req_ready, rsp_valid, eng_start});
    end
  endtask

  task automatic test_single_write();
    clear_logs();
    drive_req(0, 1'b0, 8'h0A, 8'h05);
    rr_last = 0;
    wait_rsp(1, 400);
    checks++;
    if (rsp_cyc.size() != 1) begin
      errors++; $display("FAIL wr_rsp_count: got %0d want 1", rsp_cyc.size());
    end
    checks++;
    if (start_log.size() != 1) begin
      errors++; $display("FAIL wr_start_count: got %0d want 1", start_log.size());
    end
    if (start_log.size() >= 1 && rsp_cyc.size() >= 1 && done_log.size() >= 1) begin
      checks++;
      if ({start_rw[0], start_addr[0], start_wdata[0]} !== {1'b0, 8'h0A, 8'h05}) begin
        errors++;
        $display("FAIL wr_cmd: got rw=%b a=%h d=%h want 0/0a/05",
                 start_rw[0], start_addr[0], start_wdata[0]);
      end
      checks++;
      if (rsp_cyc[0] - done_log[0] != TWR + 1) begin
        errors++;
        $display("FAIL wr_latency: got %0d want %0d", rsp_cyc[0] - done_log[0], TWR + 1);
      end
      checks++;
      if ({rsp_who[0], rsp_e[0], rsp_dat[0]} !== {32'd0, 1'b0, 8'h00}) begin
        errors++;
        $display("FAIL wr_rsp: got who=%0d err=%b d=%h want 0/0/00",
                 rsp_who[0], rsp_e[0], rsp_dat[0]);
      end
      checks++;
      if (start_log[0] - grant_cyc[0] != 1) begin
        errors++;
        $display("FAIL ready_to_start: got %0d want 1", start_log[0] - grant_cyc[0]);
      end
    end
  endtask

  task automatic test_single_read();
    clear_logs();
    rd_key = 8'h3C ^ 8'h0A;
    drive_req(1, 1'b1, 8'h0A, 8'hFF);
    rr_last = 1;
    wait_rsp(1, 400);
    checks++;
    if (rsp_cyc.size() != 1) begin
      errors++; $display("FAIL rd_rsp_count: got %0d want 1", rsp_cyc.size());
    end
    if (rsp_cyc.size() >= 1 && done_log.size() >= 1) begin
      checks++;
      if (rsp_cyc[0] - done_log[0] != 2) begin
        errors++; $display("FAIL rd_latency: got %0d want 2", rsp_cyc[0] - done_log[0]);
      end
      checks++;
      if ({rsp_who[0], rsp_e[0], rsp_dat[0]} !== {32'd1, 1'b0, 8'h3C}) begin
        errors++;
        $display("FAIL rd_rsp: got who=%0d err=%b d=%h want 1/0/3c",
                 rsp_who[0], rsp_e[0], rsp_dat[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic       rw_a [NREQ];
    logic [7:0] ad_a [NREQ];
    logic [7:0] wd_a [NREQ];
    int         w;
    logic [7:0] exp_d;
    for (int r = 0; r < 2; r++) begin
      clear_logs();
      rd_key = 8'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        rw_a[i] = (r == 0) ? 1'b1 : 1'($urandom);
        ad_a[i] = 8'($urandom);
        wd_a[i] = 8'($urandom);
      end
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) drive_req(i, rw_a[i], ad_a[i], wd_a[i]);
      wait_rsp(2, 800);
      checks++;
      if (rsp_cyc.size() != 2) begin
        errors++; $display("FAIL b2b_rsp_count: got %0d want 2", rsp_cyc.size());
      end
      for (int j = 0; j < 2 && j < rsp_cyc.size() && j < grant_log.size(); j++) begin
        w = rr_pick(2'b11 & ~((j == 1) ? (2'b01 << rr_last) : 2'b00), rr_last);
        rr_last = w;
        exp_d = rw_a[w] ? (rd_key ^ ad_a[w]) : 8'h00;
        checks++;
        if (grant_log[j] != w) begin
          errors++; $display("FAIL b2b_grant%0d: got %0d want %0d", j, grant_log[j], w);
        end
        checks++;
        if ({rsp_who[j], rsp_e[j], rsp_dat[j]} !== {w, 1'b0, exp_d}) begin
          errors++;
          $display("FAIL b2b_rsp%0d: got who=%0d err=%b d=%h want %0d/0/%h",
                   j, rsp_who[j], rsp_e[j], rsp_dat[j], w, exp_d);
        end
      end
      checks++;
      if (busy_viol != 0 || hold_viol != 0 || onehot_viol != 0) begin
        errors++;
        $display("FAIL b2b_protocol: got busy=%0d hold=%0d onehot=%0d want 0/0/0",
                 busy_viol, hold_viol, onehot_viol);
      end
    end
  endtask

  task automatic test_nack_retry();
    clear_logs();
    nack_q = '{1'b1, 1'b1, 1'b0};
    @(negedge clk);
    drive_req(0, 1'b0, 8'h33, 8'h5A);
    rr_last = 0;
    wait_rsp(1, 600);
    checks++;
    if (start_log.size() != 3 || done_log.size() != 3) begin
      errors++;
      $display("FAIL retry_starts: got %0d/%0d want 3/3", start_log.size(), done_log.size());
    end
    if (start_log.size() == 3 && done_log.size() == 3 && rsp_cyc.size() == 1) begin
      checks++;
      if (start_log[1] - done_log[0] < TWR || start_log[2] - done_log[1] < TWR) begin
        errors++;
        $display("FAIL retry_spacing: got %0d,%0d want >=%0d",
                 start_log[1] - done_log[0], start_log[2] - done_log[1], TWR);
      end
      checks++;
      if (start_addr[2] !== 8'h33 || start_wdata[2] !== 8'h5A) begin
        errors++;
        $display("FAIL retry_cmd: got %h/%h want 33/5a", start_addr[2], start_wdata[2]);
      end
      checks++;
      if ({rsp_who[0], rsp_e[0]} !== {32'd0, 1'b0} || rsp_cyc[0] - done_log[2] != TWR + 1)
      begin
        errors++;
        $display("FAIL retry_rsp: got who=%0d err=%b lat=%0d want 0/0/%0d",
                 rsp_who[0], rsp_e[0], rsp_cyc[0] - done_log[2], TWR + 1);
      end
    end
  endtask

  task automatic test_nack_exhaust();
    clear_logs();
    rd_key = 8'hA5;
    nack_q = '{1'b1, 1'b1, 1'b1};
    @(negedge clk);
    drive_req(1, 1'b1, 8'h44, 8'h00);
    rr_last = 1;
    wait_rsp(1, 600);
    repeat (60) @(negedge clk);
    checks++;
    if (start_log.size() != 3) begin
      errors++; $display("FAIL exhaust_starts: got %0d want 3", start_log.size());
    end
    checks++;
    if (rsp_cyc.size() != 1) begin
      errors++; $display("FAIL exhaust_rsp_count: got %0d want 1", rsp_cyc.size());
    end
    if (rsp_cyc.size() >= 1 && done_log.size() >= 3) begin
      checks++;
      if ({rsp_who[0], rsp_e[0], rsp_dat[0]} !== {32'd1, 1'b1, 8'h00}) begin
        errors++;
        $display("FAIL exhaust_rsp: got who=%0d err=%b d=%h want 1/1/00",
                 rsp_who[0], rsp_e[0], rsp_dat[0]);
      end
      checks++;
      if (rsp_cyc[0] - done_log[2] != 2) begin
        errors++;
        $display("FAIL exhaust_latency: got %0d want 2", rsp_cyc[0] - done_log[2]);
      end
    end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] mask, pend;
    logic            rw_a [NREQ];
    logic [7:0]      ad_a [NREQ];
    logic [7:0]      wd_a [NREQ];
    int              who_q[$], att_q[$];
    bit              err_q[$], plan[$];
    int              w, k, tot, fin, lat;
    logic [7:0]      exp_d;
    for (int r = 0; r < 10; r++) begin
      clear_logs();
      who_q.delete(); att_q.delete(); err_q.delete(); plan.delete();
      mask   = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      rd_key = 8'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        rw_a[i] = 1'($urandom); ad_a[i] = 8'($urandom); wd_a[i] = 8'($urandom);
      end
      pend = mask;
      while (pend != '0) begin
        w = rr_pick(pend, rr_last);
        pend[w] = 1'b0;
        rr_last = w;
        k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        for (int a = 0; a < k; a++) plan.push_back(1'b1);
        if (k <= MAXR) plan.push_back(1'b0);
        who_q.push_back(w);
        att_q.push_back((k <= MAXR) ? k + 1 : MAXR + 1);
        err_q.push_back(k > MAXR);
      end
      nack_q = plan;
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) if (mask[i]) drive_req(i, rw_a[i], ad_a[i], wd_a[i]);
      wait_rsp(who_q.size(), 2000);
      checks++;
      if (rsp_cyc.size() != who_q.size() || start_log.size() != plan.size()) begin
        errors++;
        $display("FAIL rnd%0d_counts: got rsp=%0d starts=%0d want %0d/%0d", r,
                 rsp_cyc.size(), start_log.size(), who_q.size(), plan.size());
      end
      tot = 0;
      for (int j = 0; j < who_q.size() && j < rsp_cyc.size(); j++) begin
        w     = who_q[j];
        fin   = tot + att_q[j] - 1;
        exp_d = (rw_a[w] && !err_q[j]) ? (rd_key ^ ad_a[w]) : 8'h00;
        checks++;
        if ({rsp_who[j], rsp_e[j], rsp_dat[j]} !== {w, err_q[j], exp_d}) begin
          errors++;
          $display("FAIL rnd%0d_rsp%0d: got who=%0d err=%b d=%h want %0d/%b/%h", r, j,
                   rsp_who[j], rsp_e[j], rsp_dat[j], w, err_q[j], exp_d);
        end
        if (fin < done_log.size()) begin
          lat = (rw_a[w] || err_q[j]) ? 2 : TWR + 1;
          checks++;
          if (rsp_cyc[j] - done_log[fin] != lat) begin
            errors++;
            $display("FAIL rnd%0d_lat%0d: got %0d want %0d", r, j,
                     rsp_cyc[j] - done_log[fin], lat);
          end
        end
        if (tot < start_addr.size()) begin
          checks++;
          if (start_addr[tot] !== ad_a[w] || start_rw[tot] !== rw_a[w]) begin
            errors++;
            $display("FAIL rnd%0d_cmd%0d: got a=%h rw=%b want %h/%b", r, j,
                     start_addr[tot], start_rw[tot], ad_a[w], rw_a[w]);
          end
        end
        tot += att_q[j];
      end
      checks++;
      if (busy_viol != 0 || hold_viol != 0 || onehot_viol != 0) begin
        errors++;
        $display("FAIL rnd%0d_protocol: got busy=%0d hold=%0d onehot=%0d want 0/0/0",
                 r, busy_viol, hold_viol, onehot_viol);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    @(negedge clk);
    // A lone requester 0 is granted, so last becomes 0 before the abort.
    drive_req(0, 1'b1, 8'h21, 8'h00);
    for (int n = 0; n < 200 && start_log.size() < 1; n++) @(negedge clk);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    req_valid = '0;
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_err, eng_start, eng_rw, eng_addr, eng_wdata}
        !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got %h want 0",
               {req_ready, rsp_valid, rsp_rdata, rsp_err, eng_start, eng_rw, eng_addr,
                eng_wdata});
    end
    @(negedge clk);
    clear_logs();
    rst = 1'b1;
    rr_last = NREQ - 1;
    rd_key = 8'h5C;
    @(negedge clk);
    drive_req(0, 1'b1, 8'h01, 8'h00);
    drive_req(1, 1'b1, 8'h02, 8'h00);
    wait_rsp(2, 800);
    checks++;
    if (rsp_cyc.size() != 2 || grant_log.size() != 2) begin
      errors++;
      $display("FAIL post_reset_count: got rsp=%0d grants=%0d want 2/2",
               rsp_cyc.size(), grant_log.size());
    end
    if (rsp_cyc.size() >= 2 && grant_log.size() >= 2) begin
      checks++;
      if (grant_log[0] != 0 || grant_log[1] != 1) begin
        errors++;
        $display("FAIL post_reset_order: got %0d,%0d want 0,1", grant_log[0], grant_log[1]);
      end
      checks++;
      if (rsp_dat[0] !== (8'h5C ^ 8'h01) || rsp_dat[1] !== (8'h5C ^ 8'h02)) begin
        errors++;
        $display("FAIL post_reset_data: got %h,%h want %h,%h", rsp_dat[0], rsp_dat[1],
                 8'h5C ^ 8'h01, 8'h5C ^ 8'h02);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    req_valid = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
    test_reset();
    test_single_write();
    test_single_read();
    test_back_to_back();
    test_nack_retry();
    test_nack_exhaust();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
